// File: rtl/huffman_byte_packer_if.sv
`default_nettype none
// ============================================================================
// Module      : huffman_byte_packer_if
// Description : Word-in / byte-out signal bundle between the Huffman coder,
//               the byte packer and the downstream byte sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface huffman_byte_packer_if;
    logic        ce;
    logic [31:0] encoded_in;
    logic [5:0]  length_in;
    logic        enable_in;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        done;
    logic        overflow;
    logic        busy;

    // Coder/sink side: drives words and ready, observes the byte stream
    modport master (
        output ce, encoded_in, length_in, enable_in, byte_ready,
        input  byte_out, byte_valid, done, overflow, busy
    );

    // Packer side
    modport slave (
        input  ce, encoded_in, length_in, enable_in, byte_ready,
        output byte_out, byte_valid, done, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/huffman_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : huffman_byte_packer
// Description : Buffers 32-bit encoded words in a small FIFO and serialises
//               them LSB-first as a byte stream. A word shorter than 32 bits
//               ends the stream: its last byte is zero-padded, then done
//               pulses for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module huffman_byte_packer #(
    parameter int DEPTH = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    huffman_byte_packer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [5:0]  bits_left_q, bits_left_d;
    logic        is_final_q, is_final_d;
    logic [7:0]  byte_out_q, byte_out_d;
    logic        byte_valid_q, byte_valid_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        overflow_q, overflow_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] mem_word_q  [DEPTH];
    logic [5:0]  mem_len_q   [DEPTH];
    logic        mem_final_q [DEPTH];

    logic        w_pop;
    logic        w_push_req;
    logic        w_push_ok;
    logic        w_fifo_empty;
    logic        w_fifo_full;
    logic [5:0]  w_len_clamped;
    logic        w_final_in;
    logic [31:0] w_head_word;
    logic [5:0]  w_head_len;
    logic        w_head_final;

    // The extra pointer bit tells a full FIFO apart from an empty one
    assign w_fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                           (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_push_req    = bus.ce && bus.enable_in;
    // Over-long lengths behave as a full 32-bit, non-final word
    assign w_len_clamped = (bus.length_in > 6'd32) ? 6'd32 : bus.length_in;
    assign w_final_in    = (bus.length_in < 6'd32);
    assign w_head_word   = mem_word_q[rd_ptr_q[AW-1:0]];
    assign w_head_len    = mem_len_q[rd_ptr_q[AW-1:0]];
    assign w_head_final  = mem_final_q[rd_ptr_q[AW-1:0]];
    // A full FIFO still accepts a push when a pop frees the slot this cycle
    assign w_push_ok     = w_push_req && (!w_fifo_full || w_pop);

    // Next-state logic: load words from the FIFO and shift bytes out
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        is_final_d  = is_final_q;
        w_pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    shreg_d     = w_head_word;
                    bits_left_d = w_head_len;
                    is_final_d  = w_head_final;
                    state_d     = (w_head_len != 6'd0) ? S_EMIT : S_DONE;
                end
            end
            S_EMIT: begin
                if (bus.byte_ready) begin
                    if (bits_left_q > 6'd8) begin
                        shreg_d     = {8'h00, shreg_q[31:8]};
                        bits_left_d = bits_left_q - 6'd8;
                    end else if (is_final_q) begin
                        state_d = S_DONE;
                    end else if (!w_fifo_empty) begin
                        // Chain straight into the next word with no bubble
                        w_pop       = 1'b1;
                        shreg_d     = w_head_word;
                        bits_left_d = w_head_len;
                        is_final_d  = w_head_final;
                        state_d     = (w_head_len != 6'd0) ? S_EMIT : S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO pointer updates and sticky overflow on a dropped word
    always_comb begin
        wr_ptr_d   = w_push_ok ? (wr_ptr_q + c_ptr_one) : wr_ptr_q;
        rd_ptr_d   = w_pop     ? (rd_ptr_q + c_ptr_one) : rd_ptr_q;
        overflow_d = overflow_q || (w_push_req && !w_push_ok);
    end

    // Registered outputs derived from the next state; padding bits forced to 0
    always_comb begin
        byte_valid_d = (state_d == S_EMIT);
        done_d       = (state_d == S_DONE);
        busy_d       = (state_d != S_IDLE) || (wr_ptr_d != rd_ptr_d);
        byte_out_d   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            byte_out_d[i] = byte_valid_d && shreg_d[i] && (6'(i) < bits_left_d);
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= 32'h0;
            bits_left_q  <= 6'd0;
            is_final_q   <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bits_left_q  <= bits_left_d;
            is_final_q   <= is_final_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            mem_word_q[wr_ptr_q[AW-1:0]]  <= bus.encoded_in;
            mem_len_q[wr_ptr_q[AW-1:0]]   <= w_len_clamped;
            mem_final_q[wr_ptr_q[AW-1:0]] <= w_final_in;
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
endmodule
`default_nettype wire

// File: tb/tb_huffman_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_huffman_byte_packer
// Description : Self-checking bench for huffman_byte_packer with a byte
//               scoreboard fed from the driven words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_byte_packer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    huffman_byte_packer_if bus ();

    huffman_byte_packer #(.DEPTH(4)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int hs_cnt       = 0;
    int done_cnt     = 0;
    int last_hs_cyc  = -10;
    int done_cyc     = -20;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc++;

    // Scoreboard: every accepted byte must match the oldest expected byte
    always @(negedge clk) begin
        logic [7:0] e;
        if (bus.byte_valid === 1'b1 && bus.byte_ready === 1'b1) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL byte_unexpected: got %02h expected no byte", bus.byte_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.byte_out !== e) begin
                    tests_failed++;
                    $display("FAIL byte_value: got %02h expected %02h", bus.byte_out, e);
                end
            end
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference byte split: ceil(len/8) bytes, LSB first, padding zeroed
    task automatic push_expected(input logic [31:0] w, input logic [5:0] l);
        int len;
        int rem;
        logic [31:0] sh;
        logic [7:0] b;
        len = (l > 6'd32) ? 32 : int'(l);
        for (int i = 0; i < (len + 7) / 8; i++) begin
            sh  = w >> (8 * i);
            b   = sh[7:0];
            rem = len - 8 * i;
            if (rem < 8) b = b & 8'((1 << rem) - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive_word(input logic [31:0] w, input logic [5:0] l, input bit keep);
        bus.ce         = 1'b1;
        bus.enable_in  = 1'b1;
        bus.encoded_in = w;
        bus.length_in  = l;
        if (keep) push_expected(w, l);
        tick();
        bus.enable_in  = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && bus.busy === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic reset_dut();
        bus.ce         = 1'b1;
        bus.enable_in  = 1'b0;
        bus.encoded_in = 32'h0;
        bus.length_in  = 6'd0;
        bus.byte_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
        hs_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic test_reset();
        bus.ce         = 1'b1;
        bus.enable_in  = 1'b0;
        bus.encoded_in = 32'h0;
        bus.length_in  = 6'd0;
        bus.byte_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.byte_out, bus.byte_valid, bus.done, bus.overflow, bus.busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got out=%02h v=%b d=%b o=%b b=%b expected all 0",
                     bus.byte_out, bus.byte_valid, bus.done, bus.overflow, bus.busy);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_two_words();
        bit to;
        int gaps;
        reset_dut();
        bus.byte_ready = 1'b1;
        drive_word(32'h44332211, 6'd32, 1'b1);
        tests_run++;
        if (bus.byte_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_words_early_valid: got %b expected 0", bus.byte_valid);
        end
        drive_word(32'h88776655, 6'd32, 1'b1);
        tests_run++;
        if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h11) begin
            tests_failed++;
            $display("FAIL two_words_latency: got v=%b out=%02h expected v=1 out=11",
                     bus.byte_valid, bus.byte_out);
        end
        gaps = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (bus.byte_valid !== 1'b1) gaps++;
        end
        tests_run++;
        if (gaps != 0) begin
            tests_failed++;
            $display("FAIL two_words_gapless: got %0d gaps expected 0", gaps);
        end
        wait_drain(40, to);
        tests_run++;
        if (to || hs_cnt != 8 || done_cnt != 0) begin
            tests_failed++;
            $display("FAIL two_words_drain: got timeout=%0d bytes=%0d done=%0d expected 0 8 0",
                     to, hs_cnt, done_cnt);
        end
    endtask

    task automatic test_final_partial();
        bit to;
        reset_dut();
        bus.byte_ready = 1'b1;
        drive_word(32'hFFFFFFFF, 6'd13, 1'b1);
        wait_drain(40, to);
        tests_run++;
        if (to || hs_cnt != 2 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL partial_drain: got timeout=%0d bytes=%0d done=%0d expected 0 2 1",
                     to, hs_cnt, done_cnt);
        end
        tests_run++;
        if (done_cyc != last_hs_cyc + 1) begin
            tests_failed++;
            $display("FAIL partial_done_timing: got done cycle %0d expected %0d",
                     done_cyc, last_hs_cyc + 1);
        end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL partial_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_boundary_end();
        bit to;
        reset_dut();
        bus.byte_ready = 1'b1;
        drive_word(32'hDDCCBBAA, 6'd32, 1'b1);
        drive_word(32'h00000000, 6'd0, 1'b1);
        wait_drain(40, to);
        tests_run++;
        if (to || hs_cnt != 4 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL boundary_drain: got timeout=%0d bytes=%0d done=%0d expected 0 4 1",
                     to, hs_cnt, done_cnt);
        end
        tests_run++;
        if (done_cyc != last_hs_cyc + 1) begin
            tests_failed++;
            $display("FAIL boundary_done_timing: got done cycle %0d expected %0d",
                     done_cyc, last_hs_cyc + 1);
        end
    endtask

    task automatic test_backpressure_overflow();
        bit to;
        logic [31:0] w;
        int unstable;
        reset_dut();
        bus.byte_ready = 1'b0;
        unstable = 0;
        for (int k = 0; k < 6; k++) begin
            w = 32'h11223344 + 32'h01010101 * k;
            if (k == 5) begin
                tests_run++;
                if (bus.overflow !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL overflow_early: got %b expected 0", bus.overflow);
                end
            end
            drive_word(w, 6'd32, k < 5);
            tick();
            if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h44) unstable++;
        end
        tests_run++;
        if (unstable != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: got %0d unstable samples expected 0", unstable);
        end
        tests_run++;
        if (bus.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_set: got %b expected 1", bus.overflow);
        end
        bus.byte_ready = 1'b1;
        wait_drain(80, to);
        tests_run++;
        if (to || hs_cnt != 20 || done_cnt != 0 || bus.overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_drain: got timeout=%0d bytes=%0d done=%0d ovf=%b expected 0 20 0 1",
                     to, hs_cnt, done_cnt, bus.overflow);
        end
    endtask

    task automatic test_ce_gating();
        bit to;
        reset_dut();
        bus.byte_ready = 1'b1;
        bus.encoded_in = 32'h000000A5;
        bus.length_in  = 6'd8;
        bus.enable_in  = 1'b1;
        bus.ce = 1'b0;
        tick();
        bus.ce = 1'b1;
        push_expected(32'h000000A5, 6'd8);
        tick();
        bus.ce = 1'b0;
        tick();
        tick();
        bus.enable_in = 1'b0;
        bus.ce = 1'b1;
        wait_drain(40, to);
        tests_run++;
        if (to || hs_cnt != 1 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL ce_gating: got timeout=%0d bytes=%0d done=%0d expected 0 1 1",
                     to, hs_cnt, done_cnt);
        end
    endtask

    task automatic test_reset_mid_stream();
        bit to;
        reset_dut();
        bus.byte_ready = 1'b0;
        drive_word(32'hC3C2C1C0, 6'd32, 1'b1);
        drive_word(32'hD3D2D1D0, 6'd32, 1'b1);
        drive_word(32'hE3E2E1E0, 6'd32, 1'b1);
        tick();
        bus.byte_ready = 1'b1;
        tick();
        bus.byte_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.byte_out, bus.byte_valid, bus.done, bus.overflow, bus.busy} !== 12'h000) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got out=%02h v=%b d=%b o=%b b=%b expected all 0",
                     bus.byte_out, bus.byte_valid, bus.done, bus.overflow, bus.busy);
        end
        exp_q.delete();
        hs_cnt   = 0;
        done_cnt = 0;
        #1 rst = 1'b0;
        tick();
        bus.byte_ready = 1'b1;
        repeat (10) tick();
        tests_run++;
        if (hs_cnt != 0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_stale: got bytes=%0d busy=%b expected 0 0", hs_cnt, bus.busy);
        end
        drive_word(32'h00000077, 6'd8, 1'b1);
        wait_drain(40, to);
        tests_run++;
        if (to || hs_cnt != 1 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL midreset_new_word: got timeout=%0d bytes=%0d done=%0d expected 0 1 1",
                     to, hs_cnt, done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_final_partial();
        test_boundary_end();
        test_backpressure_overflow();
        test_ce_gating();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
